// File: rtl/mcu_boot_pkg.sv
// mcu_boot_pkg
//   Shared definitions for the MCU boot loader: FSM state encoding, the
//   default inter-byte timeout, and a helper that classifies the states in
//   which a frame is actively being received.
package mcu_boot_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t GET_PC = 3'd1;
  localparam state_t LOAD   = 3'd2;
  localparam state_t CHECK  = 3'd3;
  localparam state_t RUN    = 3'd4;
  localparam state_t ERROR  = 3'd5;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // True in the states where the inter-byte watchdog is armed.
  function automatic logic is_loading(input state_t s);
    return (s == GET_PC) || (s == LOAD) || (s == CHECK);
  endfunction

endpackage

// File: rtl/mcu_boot_loader_timeout.sv
// boot_timeout_counter
//   Counts consecutive idle cycles while a frame is being received.
//   Ports:
//     clk_i      system clock
//     rst_i      asynchronous active-high reset
//     clear_i    restart the count (byte accepted, or not loading)
//     enable_i   this cycle is an idle loading cycle
//     expired_o  this idle cycle is the LIMIT-th in a row
module boot_timeout_counter #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // Counter holds 0..LIMIT-1; the LIMIT-th idle cycle is flagged, not stored.
  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_limit;

  assign at_limit  = (cnt_q == CNT_W'(LIMIT - 1));
  assign expired_o = enable_i & ~clear_i & at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !at_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mcu_boot_loader.sv
// mcu_boot_loader
//   Receives a boot frame (LEN, PC, LEN bytes, CHK) over a valid/ready byte
//   stream, writes the bytes to instruction memory, verifies an 8-bit wrap
//   sum and, on success, releases the MCU from reset at the received PC.
//   Ports:
//     clk_i, rst_i            clock, asynchronous active-high reset
//     in_data_i/in_valid_i    stream byte and its valid
//     in_ready_o              loader can take a byte this cycle
//     boot_req_i              abort/restart, re-hold the MCU in reset
//     imem_we_o/waddr/wdata   registered instruction memory write port
//     mcu_reset_o             reset to the MCU core
//     boot_pc_o               MCU start address
//     boot_done_o/boot_err_o  image running / image rejected or timed out
module mcu_boot_loader
  import mcu_boot_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  boot_req_i,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_waddr_o,
  output logic [7:0]            imem_wdata_o,
  output logic                  mcu_reset_o,
  output logic [7:0]            boot_pc_o,
  output logic                  boot_done_o,
  output logic                  boot_err_o
);

  // One extra bit so a full 2**ADDR_WIDTH image length is representable.
  localparam int CW = ADDR_WIDTH + 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         len_q, len_d;
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            pc_q, pc_d;

  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_waddr_q, imem_waddr_d;
  logic [7:0]            imem_wdata_q, imem_wdata_d;
  logic                  mcu_reset_q, mcu_reset_d;
  logic [7:0]            boot_pc_q, boot_pc_d;
  logic                  boot_done_q, boot_done_d;
  logic                  boot_err_q, boot_err_d;

  logic                  accept;
  logic                  loading;
  logic                  tmo_expired;
  logic [CW-1:0]         len_from_byte;
  logic [CW-1:0]         count_inc;

  assign in_ready_o = (state_q != RUN) & ~boot_req_i & ~rst_i;
  assign accept     = in_valid_i & in_ready_o;
  assign loading    = is_loading(state_q);
  assign count_inc  = count_q + 1'b1;

  // A LEN byte of zero encodes a full memory image.
  assign len_from_byte = (in_data_i == 8'd0) ? (CW'(1) << ADDR_WIDTH) : CW'(in_data_i);

  boot_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (~loading | accept | boot_req_i),
    .enable_i  (loading & ~accept),
    .expired_o (tmo_expired)
  );

  // State register and frame bookkeeping registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic. boot_req outranks both byte acceptance and timeout.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    sum_d   = sum_q;
    pc_d    = pc_q;
    if (boot_req_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ERROR: begin
          // From ERROR an accepted byte is the LEN of a fresh frame.
          if (accept) begin
            state_d = GET_PC;
            len_d   = len_from_byte;
            count_d = '0;
            sum_d   = '0;
          end
        end
        GET_PC: begin
          if (accept) begin
            pc_d    = in_data_i;
            state_d = LOAD;
          end else if (tmo_expired) begin
            state_d = ERROR;
          end
        end
        LOAD: begin
          if (accept) begin
            sum_d   = sum_q + in_data_i;
            count_d = count_inc;
            if (count_inc == len_q) begin
              state_d = CHECK;
            end
          end else if (tmo_expired) begin
            state_d = ERROR;
          end
        end
        CHECK: begin
          if (accept) begin
            state_d = (in_data_i == sum_q) ? RUN : ERROR;
          end else if (tmo_expired) begin
            state_d = ERROR;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output logic. Status flags follow the next state so they change on the
  // same edge as the transition; boot_pc only moves on CHECK->RUN.
  always_comb begin
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    boot_pc_d    = boot_pc_q;
    mcu_reset_d  = (state_d != RUN);
    boot_done_d  = (state_d == RUN);
    boot_err_d   = (state_d == ERROR);
    if ((state_q == LOAD) && accept) begin
      imem_we_d    = 1'b1;
      imem_waddr_d = count_q[ADDR_WIDTH-1:0];
      imem_wdata_d = in_data_i;
    end
    if ((state_q == CHECK) && (state_d == RUN)) begin
      boot_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      mcu_reset_q  <= 1'b1;
      boot_pc_q    <= '0;
      boot_done_q  <= 1'b0;
      boot_err_q   <= 1'b0;
    end else begin
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      mcu_reset_q  <= mcu_reset_d;
      boot_pc_q    <= boot_pc_d;
      boot_done_q  <= boot_done_d;
      boot_err_q   <= boot_err_d;
    end
  end

  assign imem_we_o    = imem_we_q;
  assign imem_waddr_o = imem_waddr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign mcu_reset_o  = mcu_reset_q;
  assign boot_pc_o    = boot_pc_q;
  assign boot_done_o  = boot_done_q;
  assign boot_err_o   = boot_err_q;

endmodule

// File: tb/tb_mcu_boot_loader.sv
module tb_mcu_boot_loader;

  localparam int AW  = 8;
  localparam int TMO = 1024;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          boot_req = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [7:0]    imem_wdata;
  logic          mcu_reset;
  logic [7:0]    boot_pc;
  logic          boot_done;
  logic          boot_err;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Reference-model state: memory writes observed, last good PC, running flag.
  logic [15:0] wr_q[$];
  logic [7:0]  exp_pc = 8'd0;
  bit          model_run = 1'b0;

  always #5 clk = ~clk;

  mcu_boot_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .boot_req_i   (boot_req),
    .imem_we_o    (imem_we),
    .imem_waddr_o (imem_waddr),
    .imem_wdata_o (imem_wdata),
    .mcu_reset_o  (mcu_reset),
    .boot_pc_o    (boot_pc),
    .boot_done_o  (boot_done),
    .boot_err_o   (boot_err)
  );

  // Write monitor: one entry per cycle the write pulse is high.
  always @(negedge clk) begin
    if (!rst && imem_we) wr_q.push_back({imem_waddr, imem_wdata});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, in_ready, 0);
    check_val({tag, "_we"}, imem_we, 0);
    check_val({tag, "_waddr"}, imem_waddr, 0);
    check_val({tag, "_wdata"}, imem_wdata, 0);
    check_val({tag, "_mcu_reset"}, mcu_reset, 1);
    check_val({tag, "_boot_pc"}, boot_pc, 0);
    check_val({tag, "_done"}, boot_done, 0);
    check_val({tag, "_err"}, boot_err, 0);
  endtask

  // Offer one byte after a random idle gap; returns just after the accepting edge.
  task automatic push_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit ok;
    gap = $urandom_range(0, max_gap);
    ok = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check_val("accept_wait", 0, 1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_boot_req();
    @(negedge clk);
    boot_req = 1'b1;
    #1;
    check_val("req_ready_low", in_ready, 0);
    check_val("req_done_before_edge", boot_done, 1);
    @(posedge clk);
    #1;
    boot_req = 1'b0;
    check_val("req_mcu_reset", mcu_reset, 1);
    check_val("req_done", boot_done, 0);
    check_val("req_err", boot_err, 0);
    model_run = 1'b0;
  endtask

  // Drive a whole frame and compare against the frame-level model.
  task automatic run_frame(input string tag, input byte_q_t fr, input int gap);
    int         len;
    logic [7:0] sum;
    bit         good;
    if (model_run) do_boot_req();
    wr_q.delete();
    foreach (fr[i]) push_byte(fr[i], gap);
    len = (fr[0] == 8'd0) ? 256 : int'(fr[0]);
    sum = 8'd0;
    for (int i = 0; i < len; i++) sum = sum + fr[2+i];
    good = (fr[len+2] == sum);
    if (good) exp_pc = fr[1];
    check_val({tag, "_mcu_reset"}, mcu_reset, !good);
    check_val({tag, "_done"}, boot_done, good);
    check_val({tag, "_err"}, boot_err, !good);
    check_val({tag, "_boot_pc"}, boot_pc, exp_pc);
    check_val({tag, "_ready"}, in_ready, !good);
    @(negedge clk);
    #1;
    check_val({tag, "_nwrites"}, wr_q.size(), len);
    for (int i = 0; i < len && i < wr_q.size(); i++)
      check_val({tag, "_write"}, wr_q[i], {8'(i), fr[2+i]});
    model_run = good;
    $display("frame %s len=%0d pc=%0h good=%0d", tag, len, fr[1], good);
  endtask

  function automatic byte_q_t make_frame(input int len, input logic [7:0] pc, input bit bad);
    byte_q_t    q;
    logic [7:0] s;
    logic [7:0] d;
    s = 8'd0;
    q.push_back(8'(len));
    q.push_back(pc);
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      s = s + d;
    end
    q.push_back(bad ? (s ^ 8'(1 + $urandom_range(0, 254))) : s);
    return q;
  endfunction

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    byte_q_t fr;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic good frame, back-to-back bytes
    run_frame("t1", '{8'h03, 8'h10, 8'hA1, 8'hB2, 8'hC3, 8'h16}, 0);

    // Bad checksum, then recovery from ERROR
    run_frame("t2_bad", '{8'h03, 8'h10, 8'hA1, 8'hB2, 8'hC3, 8'h17}, 1);
    run_frame("t2_recover", '{8'h01, 8'h00, 8'h05, 8'h05}, 1);

    // Full 256-byte image, LEN=0
    fr = '{};
    fr.push_back(8'h00);
    fr.push_back(8'h00);
    for (int i = 0; i < 256; i++) fr.push_back(8'(i));
    fr.push_back(8'h80);
    run_frame("t3_full", fr, 2);

    // Timeout after second LOAD byte
    if (model_run) do_boot_req();
    wr_q.delete();
    push_byte(8'h05, 0);
    push_byte(8'h20, 0);
    push_byte(8'hAA, 0);
    push_byte(8'hBB, 0);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check_val("tmo_not_yet", boot_err, 0);
    @(posedge clk);
    #1;
    check_val("tmo_err", boot_err, 1);
    check_val("tmo_mcu_reset", mcu_reset, 1);
    check_val("tmo_ready", in_ready, 1);
    check_val("tmo_boot_pc", boot_pc, exp_pc);
    repeat (5) @(negedge clk);
    #1;
    check_val("tmo_nwrites", wr_q.size(), 2);
    $display("timeout after %0d idle cycles err=%0d", TMO, boot_err);

    // boot_req collides with a valid LOAD byte
    wr_q.delete();
    push_byte(8'h04, 0);
    push_byte(8'h33, 0);
    push_byte(8'h11, 0);
    push_byte(8'h22, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h44;
    boot_req = 1'b1;
    #1;
    check_val("abort_ready", in_ready, 0);
    @(posedge clk);
    #1;
    boot_req = 1'b0;
    in_valid = 1'b0;
    check_val("abort_err", boot_err, 0);
    check_val("abort_mcu_reset", mcu_reset, 1);
    check_val("abort_done", boot_done, 0);
    repeat (2) @(negedge clk);
    #1;
    check_val("abort_nwrites", wr_q.size(), 2);
    if (wr_q.size() > 1) check_val("abort_pending_write", wr_q[1], {8'h01, 8'h22});
    $display("abort during load writes=%0d", wr_q.size());
    run_frame("t5_after_abort", make_frame(6, 8'h5A, 1'b0), 1);

    // Asynchronous reset mid-load with random valid backpressure
    if (model_run) do_boot_req();
    push_byte(8'h0A, 1);
    push_byte(8'h55, 1);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom), 3);
    @(negedge clk);
    in_valid = 1'($urandom);
    in_data  = 8'($urandom);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    wr_q.delete();
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'($urandom);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    exp_pc = 8'd0;
    model_run = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("midrst_no_writes", wr_q.size(), 0);
    $display("reset mid-load applied");
    run_frame("t6_reload", make_frame(10, 8'hC7, 1'b0), 3);

    // Random frames
    for (int k = 0; k < 6; k++) begin
      run_frame("rand", make_frame($urandom_range(1, 24), 8'($urandom), ($urandom_range(0, 2) == 0)), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
